alarm_sequencer: RTL and testbench

ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

---
 rtl/alarm_sequencer_if.sv | 35 +++
 rtl/alarm_sequencer.sv | 132 +++++++++++++
 tb/tb_alarm_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_sequencer_if.sv
// ---------------------------------------------------------------------------
// alarm_sequencer_if
// Bundles the alarm sequencer's control inputs and status outputs.
//   systemOn       : power-on, low forces disarm
//   arm_req        : one-cycle arm request
//   disarm_req     : one-cycle disarm request
//   motion         : motion sensor, active-low (0 = motion detected)
//   tamper_counter : 4-bit tamper event count
//   enable         : detection-path enable
//   buzzer         : siren drive
//   led0           : status LED
//   state          : current state code
// master drives the controls (system side); slave is the sequencer.
// ---------------------------------------------------------------------------
interface alarm_sequencer_if;
  logic       systemOn;
  logic       arm_req;
  logic       disarm_req;
  logic       motion;
  logic [3:0] tamper_counter;
  logic       enable;
  logic       buzzer;
  logic       led0;
  logic [2:0] state;

  modport master (
    output systemOn, arm_req, disarm_req, motion, tamper_counter,
    input  enable, buzzer, led0, state
  );

  modport slave (
    input  systemOn, arm_req, disarm_req, motion, tamper_counter,
    output enable, buzzer, led0, state
  );
endinterface

// File: rtl/alarm_sequencer.sv
// ---------------------------------------------------------------------------
// alarm_sequencer
// Arm / exit-delay / armed / entry-delay / alarm / lockout sequencer.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alarm_sequencer_if.slave (controls in, status out)
// Timed states (EXIT, ENTRY, ALARM) use one 16-bit down-timer loaded with
// N-1 on entry and left on the edge after it reaches 0, so each lasts N
// cycles. Outputs are registered from the next state/timer, so they always
// match a decode of the current state and timer registers.
// ---------------------------------------------------------------------------
module alarm_sequencer #(
  parameter int unsigned EXIT_CYCLES  = 16,
  parameter int unsigned ENTRY_CYCLES = 8,
  parameter int unsigned ALARM_CYCLES = 32,
  parameter logic [3:0]  TAMPER_LIMIT = 4'd8
) (
  input  logic            clk,
  input  logic            rst_n,
  alarm_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    EXIT     = 3'd1,
    ARMED    = 3'd2,
    ENTRY    = 3'd3,
    ALARM    = 3'd4,
    LOCKOUT  = 3'd5
  } state_t;

  localparam logic [15:0] EXIT_LOAD  = 16'(EXIT_CYCLES - 1);
  localparam logic [15:0] ENTRY_LOAD = 16'(ENTRY_CYCLES - 1);
  localparam logic [15:0] ALARM_LOAD = 16'(ALARM_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic        enable_q, buzzer_q, led0_q;
  logic        enable_d, buzzer_d, led0_d;
  logic        expired;

  assign expired = (timer_q == 16'd0);

  // Next-state selection, highest priority first.
  always_comb begin
    state_d = state_q;
    if (state_q == LOCKOUT) begin
      state_d = LOCKOUT;
    end else if (!bus.systemOn) begin
      state_d = DISARMED;
    end else if (bus.tamper_counter >= TAMPER_LIMIT) begin
      state_d = LOCKOUT;
    end else if (bus.disarm_req) begin
      state_d = DISARMED;
    end else begin
      case (state_q)
        DISARMED: if (bus.arm_req)  state_d = EXIT;
        EXIT:     if (expired)      state_d = ARMED;
        ARMED:    if (!bus.motion)  state_d = ENTRY;
        ENTRY:    if (expired)      state_d = ALARM;
        ALARM:    if (expired)      state_d = ARMED;
        default:                    state_d = DISARMED;
      endcase
    end
  end

  // Timer: load on entering a timed state, count down while staying,
  // held at zero everywhere else so no residue survives a state change.
  always_comb begin
    timer_d = '0;
    case (state_d)
      EXIT:    timer_d = (state_q != EXIT)  ? EXIT_LOAD  : timer_q - 16'd1;
      ENTRY:   timer_d = (state_q != ENTRY) ? ENTRY_LOAD : timer_q - 16'd1;
      ALARM:   timer_d = (state_q != ALARM) ? ALARM_LOAD : timer_q - 16'd1;
      default: timer_d = '0;
    endcase
  end

  // Output decode applied to the next state/timer.
  always_comb begin
    enable_d = 1'b0;
    buzzer_d = 1'b0;
    led0_d   = 1'b0;
    case (state_d)
      EXIT:    led0_d = timer_d[2];
      ARMED: begin
        enable_d = 1'b1;
        led0_d   = 1'b1;
      end
      ENTRY: begin
        enable_d = 1'b1;
        led0_d   = timer_d[2];
      end
      ALARM: begin
        enable_d = 1'b1;
        buzzer_d = 1'b1;
        led0_d   = 1'b1;
      end
      LOCKOUT: begin
        buzzer_d = 1'b1;
        led0_d   = 1'b1;
      end
      default: begin
        enable_d = 1'b0;
        buzzer_d = 1'b0;
        led0_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DISARMED;
      timer_q  <= '0;
      enable_q <= 1'b0;
      buzzer_q <= 1'b0;
      led0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      enable_q <= enable_d;
      buzzer_q <= buzzer_d;
      led0_q   <= led0_d;
    end
  end

  assign bus.state  = state_q;
  assign bus.enable = enable_q;
  assign bus.buzzer = buzzer_q;
  assign bus.led0   = led0_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alarm_sequencer
// Directed scenarios followed by randomized traffic, all checked against a
// reference model that tracks the state code and the number of cycles spent
// in it (timer value = duration - 1 - age).
// ---------------------------------------------------------------------------
module tb_alarm_sequencer;

  localparam int D_EXIT  = 16;
  localparam int D_ENTRY = 8;
  localparam int D_ALARM = 32;
  localparam int T_LIMIT = 8;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   m_state;
  int   m_age;

  alarm_sequencer_if bus ();

  alarm_sequencer #(
    .EXIT_CYCLES  (D_EXIT),
    .ENTRY_CYCLES (D_ENTRY),
    .ALARM_CYCLES (D_ALARM),
    .TAMPER_LIMIT (4'd8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dur(input int s);
    case (s)
      1:       return D_EXIT;
      3:       return D_ENTRY;
      4:       return D_ALARM;
      default: return 0;
    endcase
  endfunction

  // Reference model: one clock edge with the currently applied inputs.
  task automatic model_edge();
    int d;
    int nxt;
    bit expired;
    d = dur(m_state);
    expired = (d != 0) && (m_age == d - 1);
    if (m_state == 5)                            nxt = 5;
    else if (m_state > 5)                        nxt = 0;
    else if (!bus.systemOn)                      nxt = 0;
    else if (int'(bus.tamper_counter) >= T_LIMIT) nxt = 5;
    else if (bus.disarm_req)                     nxt = 0;
    else begin
      case (m_state)
        0:       nxt = bus.arm_req ? 1 : 0;
        1:       nxt = expired ? 2 : 1;
        2:       nxt = (bus.motion == 1'b0) ? 3 : 2;
        3:       nxt = expired ? 4 : 3;
        default: nxt = expired ? 2 : 4;
      endcase
    end
    if (nxt != m_state) m_age = 0;
    else                m_age = m_age + 1;
    m_state = nxt;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int t;
    logic e_en, e_bz, e_led;
    t = dur(m_state) - 1 - m_age;
    e_en  = (m_state == 2) || (m_state == 3) || (m_state == 4);
    e_bz  = (m_state == 4) || (m_state == 5);
    case (m_state)
      1, 3:    e_led = ((t >> 2) & 1) != 0;
      2, 4, 5: e_led = 1'b1;
      default: e_led = 1'b0;
    endcase
    chk({tag, ".state"},  16'(bus.state), 16'(m_state));
    chk({tag, ".enable"}, 16'(bus.enable), 16'(e_en));
    chk({tag, ".buzzer"}, 16'(bus.buzzer), 16'(e_bz));
    chk({tag, ".led0"},   16'(bus.led0), 16'(e_led));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  // Entered at posedge+1, leaves at posedge+1 with rst_n released.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    m_state = 0;
    m_age   = 0;
    #1;
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    rst_n = 1'b1;
  endtask

  task automatic pulse_arm(input string tag);
    bus.arm_req = 1'b1;
    step(tag);
    bus.arm_req = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_state     = 0;
    m_age       = 0;
    rst_n       = 1'b1;
    bus.systemOn       = 1'b1;
    bus.arm_req        = 1'b0;
    bus.disarm_req     = 1'b0;
    bus.motion         = 1'b1;
    bus.tamper_counter = 4'd0;
    #1;
    do_reset("reset");
    steps("idle", 2);

    // Arm: 16 cycles of EXIT, then ARMED
    pulse_arm("arm");
    chk("arm.first_exit", 16'(bus.state), 16'd1);
    steps("exit", 15);
    chk("arm.last_exit", 16'(bus.state), 16'd1);
    step("armed");
    chk("arm.state", 16'(bus.state), 16'd2);
    chk("arm.enable", 16'(bus.enable), 16'd1);
    chk("arm.led0", 16'(bus.led0), 16'd1);

    // Intrusion: 8 cycles ENTRY, 32 cycles ALARM, back to ARMED
    bus.motion = 1'b0;
    step("intr.entry");
    bus.motion = 1'b1;
    chk("intr.entry_state", 16'(bus.state), 16'd3);
    steps("intr.entry", 7);
    chk("intr.entry_last", 16'(bus.state), 16'd3);
    step("intr.alarm");
    chk("intr.alarm_state", 16'(bus.state), 16'd4);
    chk("intr.alarm_buzzer", 16'(bus.buzzer), 16'd1);
    steps("intr.alarm", 31);
    chk("intr.alarm_last", 16'(bus.state), 16'd4);
    step("intr.rearm");
    chk("intr.rearm_state", 16'(bus.state), 16'd2);
    chk("intr.rearm_buzzer", 16'(bus.buzzer), 16'd0);

    // Disarm race at the last ENTRY cycle; motion in ENTRY does not restart
    bus.motion = 1'b0;
    step("race.entry");
    steps("race.entry_motion", 7);
    bus.motion = 1'b1;
    bus.disarm_req = 1'b1;
    step("race.disarm");
    bus.disarm_req = 1'b0;
    chk("race.state", 16'(bus.state), 16'd0);
    chk("race.buzzer", 16'(bus.buzzer), 16'd0);
    bus.arm_req = 1'b1;
    bus.disarm_req = 1'b1;
    step("race.both");
    bus.arm_req = 1'b0;
    bus.disarm_req = 1'b0;
    chk("race.both_state", 16'(bus.state), 16'd0);

    // Disarm beats motion in ARMED
    pulse_arm("dm.arm");
    steps("dm.exit", 16);
    bus.disarm_req = 1'b1;
    bus.motion = 1'b0;
    step("dm.disarm");
    bus.disarm_req = 1'b0;
    bus.motion = 1'b1;
    chk("dm.state", 16'(bus.state), 16'd0);

    // Tamper lockout is sticky until reset
    pulse_arm("tamp.arm");
    bus.tamper_counter = 4'd8;
    step("tamp.lock");
    chk("tamp.state", 16'(bus.state), 16'd5);
    chk("tamp.buzzer", 16'(bus.buzzer), 16'd1);
    chk("tamp.led0", 16'(bus.led0), 16'd1);
    bus.tamper_counter = 4'd0;
    bus.systemOn = 1'b0;
    bus.disarm_req = 1'b1;
    steps("tamp.sticky", 3);
    chk("tamp.sticky_state", 16'(bus.state), 16'd5);
    bus.systemOn = 1'b1;
    bus.disarm_req = 1'b0;
    do_reset("tamp.reset");
    chk("tamp.reset_state", 16'(bus.state), 16'd0);

    // Motion ignored in EXIT, power loss during ALARM
    pulse_arm("pwr.arm");
    bus.motion = 1'b0;
    steps("pwr.exit_motion", 3);
    chk("pwr.exit_state", 16'(bus.state), 16'd1);
    bus.motion = 1'b1;
    steps("pwr.exit", 13);
    bus.motion = 1'b0;
    step("pwr.entry");
    bus.motion = 1'b1;
    steps("pwr.entry", 8);
    steps("pwr.alarm", 5);
    chk("pwr.alarm_state", 16'(bus.state), 16'd4);
    bus.systemOn = 1'b0;
    step("pwr.off");
    chk("pwr.off_state", 16'(bus.state), 16'd0);
    chk("pwr.off_buzzer", 16'(bus.buzzer), 16'd0);
    bus.systemOn = 1'b1;

    // Reset mid-delay leaves no timer residue for the next arming
    pulse_arm("mid.arm");
    steps("mid.exit", 5);
    do_reset("mid.reset");
    pulse_arm("mid.rearm");
    steps("mid.exit2", 15);
    chk("mid.exit2_state", 16'(bus.state), 16'd1);
    step("mid.armed");
    chk("mid.armed_state", 16'(bus.state), 16'd2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.systemOn       = ($urandom_range(0, 299) != 0);
      bus.arm_req        = ($urandom_range(0, 5) == 0);
      bus.disarm_req     = ($urandom_range(0, 39) == 0);
      bus.motion         = ($urandom_range(0, 5) != 0);
      bus.tamper_counter = ($urandom_range(0, 399) == 0) ? 4'($urandom_range(8, 15))
                                                         : 4'($urandom_range(0, 7));
      if ((m_state == 5 && $urandom_range(0, 9) == 0) || $urandom_range(0, 799) == 0)
        do_reset("rnd.reset");
      else
        step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
